// File: rtl/cic_dec_ctrl.sv
// Sequencing controller for the CIC decimator: input-sample strobe, decimation strobe,
// datapath clear and comb warm-up suppression, with run-time changes of the decimation factor.
module cic_dec_ctrl #(
   parameter int CLK_DIV        = 3,
   parameter int Q              = 3,
   parameter int MAX_LOG2_D     = 4,
   parameter int DEFAULT_LOG2_D = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       cfg_valid,
   input  logic [2:0] cfg_log2_d,
   output logic       cfg_ready,
   output logic       cfg_err,
   output logic       integ_en,
   output logic       dec_en,
   output logic       cic_clear,
   output logic       out_valid,
   output logic [2:0] log2_d_active,
   output logic [1:0] state
);

   localparam int WW = (Q < 1) ? 1 : $clog2(Q + 1);
   localparam int DW = MAX_LOG2_D + 1;
   localparam logic [1:0]    PH_LAST  = 2'(CLK_DIV - 1);
   localparam logic [WW-1:0] WARM_MAX = WW'(Q);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_CLEAR = 2'b01,
      S_RUN   = 2'b10
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            phase_q, phase_d;
   logic [MAX_LOG2_D-1:0] decim_q, decim_d;
   logic [WW-1:0]         warm_q, warm_d;
   logic                  pend_q, pend_d;
   logic [2:0]            pend_val_q, pend_val_d;
   logic [2:0]            log2_d_q, log2_d_d;
   logic                  cfg_ready_q, cfg_ready_d;
   logic                  cfg_err_q, cfg_err_d;
   logic                  integ_en_q, integ_en_d;
   logic                  dec_en_q, dec_en_d;
   logic                  cic_clear_q, cic_clear_d;
   logic                  out_valid_q, out_valid_d;
   logic                  cfg_legal;

   // Terminal value of the decimation counter for a given log2(D).
   function automatic logic [MAX_LOG2_D-1:0] d_max(input logic [2:0] l2);
      logic [DW-1:0] one_hot;
      one_hot = DW'(1) << l2;
      return MAX_LOG2_D'(one_hot - DW'(1));
   endfunction

   assign cfg_legal = (cfg_log2_d <= 3'(MAX_LOG2_D));

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      decim_d    = decim_q;
      warm_d     = warm_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      log2_d_d   = log2_d_q;
      cfg_err_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            phase_d = '0;
            decim_d = '0;
            warm_d  = '0;
            // A fresh config offered here supersedes one carried over from RUN.
            if (cfg_valid && cfg_legal)
               log2_d_d = cfg_log2_d;
            else if (pend_q)
               log2_d_d = pend_val_q;
            pend_d    = 1'b0;
            cfg_err_d = cfg_valid && !cfg_legal;
            if (enable)
               state_d = S_CLEAR;
         end
         S_CLEAR: begin
            phase_d = '0;
            decim_d = '0;
            warm_d  = '0;
            if (pend_q) begin
               log2_d_d = pend_val_q;
               pend_d   = 1'b0;
            end
            state_d = enable ? S_RUN : S_IDLE;
         end
         S_RUN: begin
            phase_d = (phase_q == PH_LAST) ? 2'd0 : phase_q + 2'd1;
            if (integ_en_q)
               decim_d = (decim_q == d_max(log2_d_q)) ? '0 : decim_q + 1'b1;
            if (dec_en_q && (warm_q != WARM_MAX))
               warm_d = warm_q + 1'b1;
            if (cfg_valid && cfg_ready_q) begin
               if (cfg_legal) begin
                  pend_d     = 1'b1;
                  pend_val_d = cfg_log2_d;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
            // pend_q is still low in the accept cycle, so that cycle's dec_en never applies it.
            if (dec_en_q && pend_q)
               state_d = S_CLEAR;
            else if (!enable)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      integ_en_d  = (state_d == S_RUN) && (phase_d == PH_LAST);
      dec_en_d    = integ_en_d && (decim_d == d_max(log2_d_d));
      out_valid_d = dec_en_q && (warm_q == WARM_MAX) && (state_d != S_IDLE);
      cic_clear_d = (state_d == S_CLEAR);
      cfg_ready_d = (state_d == S_IDLE) || ((state_d == S_RUN) && !pend_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         phase_q     <= '0;
         decim_q     <= '0;
         warm_q      <= '0;
         pend_q      <= 1'b0;
         pend_val_q  <= '0;
         log2_d_q    <= 3'(DEFAULT_LOG2_D);
         cfg_ready_q <= 1'b1;
         cfg_err_q   <= 1'b0;
         integ_en_q  <= 1'b0;
         dec_en_q    <= 1'b0;
         cic_clear_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         decim_q     <= decim_d;
         warm_q      <= warm_d;
         pend_q      <= pend_d;
         pend_val_q  <= pend_val_d;
         log2_d_q    <= log2_d_d;
         cfg_ready_q <= cfg_ready_d;
         cfg_err_q   <= cfg_err_d;
         integ_en_q  <= integ_en_d;
         dec_en_q    <= dec_en_d;
         cic_clear_q <= cic_clear_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign cfg_ready     = cfg_ready_q;
   assign cfg_err       = cfg_err_q;
   assign integ_en      = integ_en_q;
   assign dec_en        = dec_en_q;
   assign cic_clear     = cic_clear_q;
   assign out_valid     = out_valid_q;
   assign log2_d_active = log2_d_q;
   assign state         = state_q;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl: strobe timing for D = 1/4/8, warm-up suppression,
// config handshake, illegal config, enable drop and asynchronous reset with a pending config.
module tb_cic_dec_ctrl;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       cfg_valid;
   logic [2:0] cfg_log2_d;
   logic       cfg_ready;
   logic       cfg_err;
   logic       integ_en;
   logic       dec_en;
   logic       cic_clear;
   logic       out_valid;
   logic [2:0] log2_d_active;
   logic [1:0] state;

   int n_checks = 0;
   int n_errors = 0;

   cic_dec_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .cfg_valid     (cfg_valid),
      .cfg_log2_d    (cfg_log2_d),
      .cfg_ready     (cfg_ready),
      .cfg_err       (cfg_err),
      .integ_en      (integ_en),
      .dec_en        (dec_en),
      .cic_clear     (cic_clear),
      .out_valid     (out_valid),
      .log2_d_active (log2_d_active),
      .state         (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected {state, cic_clear, integ_en, dec_en, out_valid} for cycle k after entering CLEAR
   // (CLEAR itself is k = 1), CLK_DIV = 3, Q = 3, decimation factor d.
   function automatic logic [5:0] exp_vec(input int k, input int d);
      logic [1:0] st;
      logic       clr, ig, de, ov;
      st  = (k == 1) ? 2'b01 : 2'b10;
      clr = (k == 1);
      ig  = (k >= 4) && ((k - 1) % 3 == 0);
      de  = ig && (((k - 1) / 3) % d == 0);
      ov  = (k >= 5) && ((k - 2) % 3 == 0) && ((((k - 2) / 3) % d) == 0)
            && ((((k - 2) / 3) / d) >= 4);
      return {st, clr, ig, de, ov};
   endfunction

   task automatic run_pattern(input int d, input int k_from, input int k_to);
      for (int k = k_from; k <= k_to; k++) begin
         @(negedge clk);
         check($sformatf("pat_d%0d_k%0d", d, k),
               32'({state, cic_clear, integ_en, dec_en, out_valid}), 32'(exp_vec(k, d)));
      end
      $display("[%0t] pattern D=%0d cycles %0d..%0d done", $time, d, k_from, k_to);
   endtask

   task automatic offer_cfg(input logic [2:0] l2);
      cfg_valid  = 1'b1;
      cfg_log2_d = l2;
   endtask

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      cfg_valid  = 1'b0;
      cfg_log2_d = 3'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_vec",    32'({state, cic_clear, integ_en, dec_en, out_valid}), 32'h0);
      check("rst_ready",  32'(cfg_ready), 32'd1);
      check("rst_err",    32'(cfg_err), 32'd0);
      check("rst_log2d",  32'(log2_d_active), 32'd0);
      $display("[%0t] reset state checked", $time);

      // D = 1 from reset: clear at 1, strobes at 4,7,..., out_valid from 14
      rst_n  = 1'b1;
      enable = 1'b1;
      run_pattern(1, 1, 20);

      // Enable drop, then load log2_d = 2 in IDLE
      enable = 1'b0;
      @(negedge clk);
      check("idle_vec", 32'({state, cic_clear, integ_en, dec_en, out_valid}), 32'h0);
      offer_cfg(3'd2);
      @(negedge clk);
      check("idle_cfg_log2d", 32'(log2_d_active), 32'd2);
      check("idle_cfg_err",   32'(cfg_err), 32'd0);
      cfg_valid = 1'b0;
      enable    = 1'b1;
      run_pattern(4, 1, 52);

      // Accept log2_d = 3 between dec_ens; next dec_en at k = 61 applies it
      check("acc_ready_before", 32'(cfg_ready), 32'd1);
      offer_cfg(3'd3);
      run_pattern(4, 53, 53);
      check("acc_ready_low", 32'(cfg_ready), 32'd0);
      cfg_valid = 1'b0;
      run_pattern(4, 54, 61);
      check("acc_ready_at_dec", 32'(cfg_ready), 32'd0);
      check("acc_log2d_old",    32'(log2_d_active), 32'd2);
      @(negedge clk);
      check("acc_clear", 32'({state, cic_clear, integ_en, dec_en}), 32'b01100);
      run_pattern(8, 2, 2);
      check("acc_log2d_new",  32'(log2_d_active), 32'd3);
      check("acc_ready_back", 32'(cfg_ready), 32'd1);
      run_pattern(8, 3, 30);

      // Illegal log2_d = 5 while ready: one cfg_err pulse, nothing else changes
      offer_cfg(3'd5);
      run_pattern(8, 31, 31);
      check("ill_err_pulse", 32'(cfg_err), 32'd1);
      cfg_valid = 1'b0;
      run_pattern(8, 32, 32);
      check("ill_err_end",  32'(cfg_err), 32'd0);
      check("ill_log2d",    32'(log2_d_active), 32'd3);
      check("ill_ready",    32'(cfg_ready), 32'd1);
      run_pattern(8, 33, 100);

      // Enable dropped mid-RUN: IDLE, silent; re-enable gives full warm-up
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("drop_idle_%0d", i),
               32'({state, cic_clear, integ_en, dec_en, out_valid}), 32'h0);
      end
      offer_cfg(3'd0);
      @(negedge clk);
      check("drop_log2d", 32'(log2_d_active), 32'd0);
      cfg_valid = 1'b0;
      enable    = 1'b1;
      run_pattern(1, 1, 20);

      // Async reset between accept and the applying dec_en (next dec_en at k = 22)
      offer_cfg(3'd2);
      @(negedge clk);
      check("ar_ready_low", 32'(cfg_ready), 32'd0);
      cfg_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("ar_vec",   32'({state, cic_clear, integ_en, dec_en, out_valid}), 32'h0);
      check("ar_ready", 32'(cfg_ready), 32'd1);
      check("ar_err",   32'(cfg_err), 32'd0);
      check("ar_log2d", 32'(log2_d_active), 32'd0);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("ar_post_log2d", 32'(log2_d_active), 32'd0);
      check("ar_post_state", 32'(state), 32'd0);
      enable = 1'b1;
      run_pattern(1, 1, 15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
Sequencing controller for the CIC decimator in the DFE filter array. Runs on the 18 MHz clock and generates the 6 MHz input-sample strobe, the integrator enable, and the decimation/comb enable. Accepts run-time changes of the decimation factor D = 2^log2_d and applies each change safely: clear the datapath, then suppress output during comb warm-up. Flags which decimated outputs are valid.

Parameters:
CLK_DIV, 3, clk cycles per input sample (18 MHz / 6 MHz)
Q, 3, CIC order; number of decimated outputs suppressed after every clear
MAX_LOG2_D, 4, largest legal log2_d (D = 16)
DEFAULT_LOG2_D, 0, log2_d loaded at reset

Ports:
clk  in  1  18 MHz clock
rst_n  in  1  asynchronous, active-low reset
enable  in  1  level; 1 = run the filter
cfg_valid  in  1  new decimation config offered
cfg_log2_d  in  3  requested log2(D)
cfg_ready  out  1  controller can accept a config this cycle
cfg_err  out  1  one-cycle pulse: offered config rejected
integ_en  out  1  one-cycle pulse per input sample; integrator and input-capture enable
dec_en  out  1  one-cycle pulse per decimated sample; downsampler and comb enable
cic_clear  out  1  one-cycle synchronous clear of all integrator, comb and downsampler registers
out_valid  out  1  one-cycle pulse: comb output registered on the previous dec_en is valid
log2_d_active  out  3  log2_d currently in use (drives datapath shift/normalisation)
state  out  2  00 IDLE, 01 CLEAR, 10 RUN

Behaviour:
- All outputs are registered. Reset values:
  - integ_en, dec_en, cic_clear, out_valid, cfg_err = 0
  - cfg_ready = 1; state = IDLE
  - log2_d_active = DEFAULT_LOG2_D
  - phase, decim and warm-up counters = 0; pending-config flag = 0
- Reset asserted mid-operation aborts immediately. Any pending config is discarded.

Counters:
- phase: 0..CLK_DIV-1 (2 bits).
- decim: 0..(1<<log2_d_active)-1 (MAX_LOG2_D bits).
- warm: saturating 0..Q.

IDLE:
- No integ_en, dec_en or out_valid. cfg_ready = 1.
- A legal cfg (cfg_log2_d <= MAX_LOG2_D) loads log2_d_active on the next edge.
- enable = 1 -> CLEAR.

CLEAR (exactly 1 cycle):
- cic_clear = 1.
- phase, decim and warm are zeroed.
- If the pending flag is set, pending log2_d loads into log2_d_active and the flag clears.
- Next state: RUN if enable = 1, else IDLE.

RUN:
- phase increments every cycle and wraps at CLK_DIV-1.
- integ_en = 1 in the cycle phase == CLK_DIV-1. The first integ_en is on the CLK_DIV-th cycle in RUN.
- On each integ_en, decim increments and wraps at D-1.
- dec_en = 1 in the same cycle as the integ_en for which decim == D-1. With D = 1, dec_en equals integ_en.
- On each dec_en, warm increments (saturating at Q).
- out_valid pulses the cycle after a dec_en only if warm was already Q at that dec_en. The first Q decimated outputs after a clear are therefore suppressed.
- enable = 0 -> IDLE on the next edge. Strobes stop from that edge. A pending config is kept.

Config handshake in RUN:
- cfg_ready = 1 while no config is pending.
- Legal cfg_valid & cfg_ready: store cfg_log2_d as pending; cfg_ready drops next cycle.
- The pending config is applied at the next dec_en after the accept cycle. A dec_en in the accept cycle itself does not count.
  - That dec_en still pulses normally.
  - The next state is CLEAR, which loads the new D.
- cfg_valid while cfg_ready = 0 is ignored (no cfg_err).
- Illegal cfg_log2_d (> MAX_LOG2_D) offered while cfg_ready = 1: cfg_err pulses next cycle; nothing is stored and operation is unaffected.

Simultaneous and boundary cases:
- enable falling in the same cycle as the applying dec_en: go to CLEAR (load D), then IDLE.
- IDLE with a pending flag and enable = 0: the pending value loads into log2_d_active on the next edge and the flag clears.
- phase and decim never exceed their wrap values, including right after a change of D.

Test Plan:
- Reset, enable = 1, D = 1 (log2_d = 0): cic_clear at cycle 1; integ_en and dec_en on cycles 4, 7, 10, ...; out_valid first at the cycle after the 4th dec_en (cycle 14), then every 3 cycles.
- log2_d = 2 set in IDLE, then enable: dec_en every 12 cycles, at the 4th, 8th, ... integ_en; log2_d_active = 2; integ_en never gaps.
- RUN with D = 4; accept cfg_log2_d = 3 between dec_ens: cfg_ready = 0 until the next dec_en; that dec_en pulses, then 1-cycle cic_clear; dec_en resumes every 24 cycles; 3 dec_ens without out_valid; log2_d_active = 3.
- cfg_log2_d = 5 offered with cfg_ready = 1: cfg_err pulse one cycle later; log2_d_active and strobe timing unchanged.
- enable dropped mid-RUN: state IDLE next edge; no strobes; re-enable produces cic_clear and a full warm-up again.
- rst_n asserted asynchronously between the accept and the applying dec_en: all outputs at reset values immediately; after release, log2_d_active = DEFAULT_LOG2_D and the pending config is lost.
